// File: rtl/link_tx_packetizer_pkg.sv
// Shared types and header field layout for the link TX packetizer.
package link_tx_packetizer_pkg;

    typedef enum logic [1:0] {
        ACCUM       = 2'd0,
        WAIT_CREDIT = 2'd1,
        SEND_HDR    = 2'd2,
        SEND_PAY    = 2'd3
    } pkt_state_t;

    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_W    = 8;
    localparam int HDR_SEQ_LSB  = 8;
    localparam int HDR_SEQ_W    = 16;
    localparam int HDR_DEST_LSB = 24;
    localparam int HDR_DEST_W   = 8;
    localparam int HDR_LAST_BIT = 32;

endpackage

// File: rtl/link_tx_packetizer_buf.sv
// Payload beat store: one indexed write port, one indexed combinational read port.
module link_pkt_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // No reset: contents are only read below the valid count, which resets.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/link_tx_packetizer.sv
// Packs DMA stream beats into credit-gated link packets: one header beat then payload.
module link_tx_packetizer
    import link_tx_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int MAX_BEATS    = 8,
    parameter int CREDIT_WIDTH = 8,
    parameter int INIT_CREDITS = 32,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tlast,
    input  logic [7:0]              dest_id,
    output logic                    l_valid,
    input  logic                    l_ready,
    output logic [DATA_WIDTH-1:0]   l_data,
    output logic                    l_sop,
    output logic                    l_eop,
    input  logic [CREDIT_WIDTH-1:0] credit_ret
);

    localparam int CNT_W  = 8;
    localparam int IDX_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int SUM_W  = ((CREDIT_WIDTH > CNT_W) ? CREDIT_WIDTH : CNT_W) + 2;
    localparam logic [SUM_W-1:0] CRED_MAX = SUM_W'((1 << CREDIT_WIDTH) - 1);

    pkt_state_t            state, nxt;
    logic [CNT_W-1:0]      cnt, rd_idx;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [15:0]           seq;
    logic                  last_flag;
    logic [CREDIT_WIDTH-1:0] credits;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_build, buf_rd;
    logic [SUM_W-1:0]      cred_sum, need, deduct, net;
    logic                  acc, idle_hit, pay_done;

    assign s_tready = rst_n && (state == ACCUM) && (cnt < CNT_W'(MAX_BEATS));
    assign acc      = s_tvalid && s_tready;
    assign idle_hit = (state == ACCUM) && (cnt != '0) && !acc &&
                      (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
    assign pay_done = (state == SEND_PAY) && l_ready && l_eop;

    // Returned credits and the header deduction net in one update, then clamp.
    assign cred_sum = SUM_W'(credits) + SUM_W'(credit_ret);
    assign need     = SUM_W'(cnt) + SUM_W'(1);
    assign deduct   = (state == SEND_HDR && l_ready) ? need : '0;
    assign net      = cred_sum - deduct;

    always_comb begin
        hdr_build = '0;
        hdr_build[HDR_CNT_LSB  +: HDR_CNT_W]  = cnt;
        hdr_build[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
        hdr_build[HDR_DEST_LSB +: HDR_DEST_W] = dest_id;
        hdr_build[HDR_LAST_BIT]               = last_flag;
    end

    link_pkt_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_BEATS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we      (acc),
        .wr_idx  (cnt[IDX_W-1:0]),
        .wr_data (s_tdata),
        .rd_idx  (rd_idx[IDX_W-1:0]),
        .rd_data (buf_rd)
    );

    always_comb begin
        nxt     = state;
        l_valid = 1'b0;
        l_sop   = 1'b0;
        l_eop   = 1'b0;
        l_data  = '0;
        case (state)
            ACCUM: begin
                if (acc && ((cnt + CNT_W'(1) == CNT_W'(MAX_BEATS)) || s_tlast)) nxt = WAIT_CREDIT;
                else if (idle_hit) nxt = WAIT_CREDIT;
            end
            WAIT_CREDIT: begin
                if (cred_sum >= need) nxt = SEND_HDR;
            end
            SEND_HDR: begin
                l_valid = 1'b1;
                l_sop   = 1'b1;
                l_data  = hdr_q;
                if (l_ready) nxt = SEND_PAY;
            end
            SEND_PAY: begin
                l_valid = 1'b1;
                l_data  = buf_rd;
                l_eop   = (rd_idx == cnt - CNT_W'(1));
                if (l_ready && l_eop) nxt = ACCUM;
            end
            default: nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            rd_idx    <= '0;
            idle_cnt  <= '0;
            seq       <= '0;
            last_flag <= 1'b0;
            credits   <= CREDIT_WIDTH'(INIT_CREDITS);
            hdr_q     <= '0;
        end else begin
            state    <= nxt;
            credits  <= (net > CRED_MAX) ? CRED_MAX[CREDIT_WIDTH-1:0] : net[CREDIT_WIDTH-1:0];
            idle_cnt <= (state == ACCUM && cnt != '0 && !acc) ? idle_cnt + IDLE_W'(1) : '0;
            if (acc) begin
                cnt <= cnt + CNT_W'(1);
                if (s_tlast) last_flag <= 1'b1;
            end
            // Snapshot the header so dest_id changes cannot disturb a stalled beat.
            if (state == WAIT_CREDIT && nxt == SEND_HDR) hdr_q <= hdr_build;
            if (state == SEND_PAY && l_ready) begin
                if (pay_done) begin
                    rd_idx    <= '0;
                    cnt       <= '0;
                    last_flag <= 1'b0;
                    seq       <= seq + 16'd1;
                end else begin
                    rd_idx <= rd_idx + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/link_tx_packetizer.md
LINK_TX_PACKETIZER -- requirements
Module: link_tx_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 512: width of stream and link data beats.
REQ-002 Parameter MAX_BEATS, default 8: maximum payload beats per packet, range 1..255.
REQ-003 Parameter CREDIT_WIDTH, default 8: width of the credit counter.
REQ-004 Parameter INIT_CREDITS, default 32: credit count loaded at reset, at most 2^CREDIT_WIDTH-1.
REQ-005 Parameter IDLE_TIMEOUT, default 16: idle cycles before a partial packet is flushed, at least 1.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 s_tvalid / s_tready  input / output  1 / 1  AXI-Stream beat handshake from the scatter-gather DMA.
REQ-009 s_tdata  input  DATA_WIDTH  payload beat.
REQ-010 s_tlast  input  1  marks the final beat of a DMA transfer.
REQ-011 dest_id  input  8  destination GPU ID, sampled when the header is built.
REQ-012 l_valid / l_ready  output / input  1 / 1  link beat handshake.
REQ-013 l_data  output  DATA_WIDTH  link beat (header or payload).
REQ-014 l_sop / l_eop  output  1 / 1  first and last beat of a link packet.
REQ-015 credit_ret  input  CREDIT_WIDTH  credits returned by the receiver this cycle (0 = none).

Function
REQ-016 States: ACCUM, WAIT_CREDIT, SEND_HDR, SEND_PAY; reset state is ACCUM.
REQ-017 ACCUM: s_tready=1 while the payload buffer holds fewer than MAX_BEATS beats; each accepted beat is written at index cnt, and cnt increments.
REQ-018 Packet close conditions, all evaluated in ACCUM:
- the accepted beat makes cnt equal MAX_BEATS;
- the accepted beat carries s_tlast (sets last_flag);
- idle_cnt reaches IDLE_TIMEOUT with cnt>0.
REQ-019 idle_cnt clears on every accepted beat and increments otherwise in ACCUM; it holds at 0 while cnt=0.
REQ-020 On close, the FSM enters WAIT_CREDIT on the next cycle, and s_tready is 0 outside ACCUM.
REQ-021 WAIT_CREDIT advances to SEND_HDR in the same cycle credits >= cnt+1; credits are evaluated after adding that cycle's credit_ret.
REQ-022 Header beat layout:
- [7:0] cnt (payload beats, 1..MAX_BEATS);
- [23:8] seq;
- [31:24] dest_id;
- [32] last_flag;
- all other bits 0.
REQ-023 SEND_HDR: l_valid=1, l_sop=1, l_eop=0, l_data=header. On l_ready, credits decrease by cnt+1 and the FSM enters SEND_PAY.
REQ-024 SEND_PAY: l_valid=1 and l_data=buffer[rd_idx]; l_eop=1 when rd_idx=cnt-1. Each l_ready advances rd_idx.
REQ-025 On the eop handshake:
- seq increments, wrapping 0xFFFF to 0;
- cnt, rd_idx and last_flag clear;
- the FSM returns to ACCUM.
REQ-026 While l_valid=1 and l_ready=0, l_data, l_sop and l_eop hold stable.
REQ-027 credit_ret is added every cycle in every state. A simultaneous add and deduct nets both in the same cycle. The counter saturates at 2^CREDIT_WIDTH-1.
REQ-028 Latency: close on cycle N produces header l_valid no earlier than cycle N+2 (one cycle for ACCUM to WAIT_CREDIT, one for WAIT_CREDIT to SEND_HDR).
REQ-029 A packet never carries beats from two DMA transfers; a beat with s_tlast always closes the packet.

Reset
REQ-030 Reset values:
- s_tready=0 during reset and 1 on the first cycle after release;
- l_valid, l_sop, l_eop = 0; l_data = 0;
- cnt, rd_idx, idle_cnt, seq, last_flag = 0;
- credits = INIT_CREDITS.
REQ-031 Reset asserted mid-packet discards buffered beats immediately; no partial packet is emitted after release.

Structure
REQ-032 A shared package holds the state enum, the header field offsets and widths, and the HDR_LAST_BIT constant.
REQ-033 The payload buffer is one sub-module, link_pkt_buf: a MAX_BEATS x DATA_WIDTH register array with one write port and one read port, written by index and read by index.

Verification
REQ-034 Send 8 beats with no tlast and credits=32: one header with cnt=8, seq=0, last=0, then 8 payload beats in order; eop on beat 8; credits end at 23.
REQ-035 Send 3 beats with tlast on beat 3: header cnt=3, last=1; the next transfer's header has seq=1.
REQ-036 Send 2 beats then hold s_tvalid=0 for 16 cycles: the partial packet flushes with header cnt=2, last=0.
REQ-037 Set credits=4, send 8 beats: the FSM stalls in WAIT_CREDIT. Return credit_ret=5 in one cycle: the header issues next cycle and credits end at 0.
REQ-038 Toggle l_ready randomly during a packet: l_data, l_sop and l_eop stay stable while stalled, and no beat is lost or duplicated.
REQ-039 Assert rst_n=0 during SEND_PAY: l_valid drops immediately and credits read 32 after release.
